uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares the single `uart_top` transmitter among `NUM_REQ` on-chip requesters. It accepts one byte per grant through a valid/ready handshake, drives `data_in`/`tx_en` of `uart_top`, and tracks `tx_busy` to detect frame start and frame end. It reports completion and start-timeout errors per frame, and sits between the requester logic and the `uart_top` instance.

## Interface
- `SIZE`, 8, data width per frame (matches `uart_top` SIZE)
- `NUM_REQ`, 4, number of requesters (≥2); `IDW = $clog2(NUM_REQ)`
- `START_TIMEOUT`, 16, clk cycles allowed from `uart_tx_en` pulse to `uart_tx_busy` rising (≥2)

- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_REQ  per-requester request; held until that requester's `req_ready` pulse
- `req_data`  in  NUM_REQ*SIZE  requester i's data in bits [i*SIZE +: SIZE]; stable while `req_valid[i]`=1
- `req_ready`  out  NUM_REQ  one-cycle accept pulse, one-hot
- `uart_data_in`  out  SIZE  to `uart_top.data_in`; holds the captured byte until the next grant
- `uart_tx_en`  out  1  to `uart_top.tx_en`; one-cycle start pulse
- `uart_tx_busy`  in  1  from `uart_top.tx_busy`
- `grant_id`  out  IDW  index of the requester currently or most recently granted
- `frame_done`  out  1  one-cycle pulse when the granted frame finishes
- `frame_done_id`  out  IDW  requester index for `frame_done` / `start_err`
- `start_err`  out  1  one-cycle pulse on start timeout
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, LOAD, WAIT_START, WAIT_END.
- IDLE: if any `req_valid` is high, pick a winner round-robin. The search starts at `last_grant+1` mod NUM_REQ and takes the first valid index found. On that edge: `uart_data_in` ← winner's data, `grant_id`/`last_grant` ← winner, `req_ready[winner]` ← 1, go to LOAD.
- LOAD (exactly 1 cycle): `uart_tx_en`=1 and `req_ready[winner]`=1 in this cycle; clear start counter; go to WAIT_START.
- WAIT_START: count cycles.
  - If `uart_tx_busy`=1, go to WAIT_END.
  - Else, when the count reaches START_TIMEOUT-1, pulse `start_err` with `frame_done_id`=grant and go to IDLE. No `frame_done` is issued.
- WAIT_END: when `uart_tx_busy`=0, pulse `frame_done` with `frame_done_id`=grant and go to IDLE.
- All outputs are registered. `busy` = (state ≠ IDLE).
- Round-robin pointer:
  - reset value of `last_grant` is NUM_REQ-1, so requester 0 wins first;
  - the pointer updates on every grant, including grants that later time out.
- `req_valid` is sampled only in IDLE. Valid dropped before grant means no grant and no error. Valid asserted during a frame waits for the next IDLE.
- Only one frame is in flight at a time. `uart_data_in` stays stable from LOAD through WAIT_END.

## Timing
- Reset values: `req_ready`=0, `uart_tx_en`=0, `uart_data_in`=0, `grant_id`=0, `frame_done`=0, `frame_done_id`=0, `start_err`=0, `busy`=0, state=IDLE, `last_grant`=NUM_REQ-1.
- Valid sampled in IDLE at edge N → `req_ready`/`uart_tx_en` high during cycle N+1 → earliest `uart_tx_busy` sample at edge N+2.
- `frame_done` is high the cycle after the edge that samples `uart_tx_busy`=0 in WAIT_END. The next grant can be sampled at the edge following `frame_done` (one IDLE cycle between frames).
- Timeout: `start_err` is high START_TIMEOUT cycles after the LOAD cycle when `uart_tx_busy` stays 0 throughout.
- `uart_tx_busy` high and low within WAIT_START without being sampled high: not detected, so the timeout applies. `uart_top` must hold `tx_busy` for the whole frame.
- Reset mid-frame:
  - all outputs return to reset values on the next edge;
  - the accepted byte is dropped with no `frame_done` or `start_err`;
  - arbitration restarts at requester 0.
- `rst` has priority over every transition, including a simultaneous grant.

## Test plan
- Single request: `req_valid[2]`=1, data 0xA5 → `req_ready[2]` and `uart_tx_en` pulse together one cycle later, `uart_data_in`=0xA5. In loopback, `uart_top` `data_out`=0xA5 with `rx_done`; then `frame_done`=1, `frame_done_id`=2.
- Contention: requesters 0–3 all valid continuously with data 0x10–0x13 → grant order 0,1,2,3,0; each `req_ready` is one-hot; received bytes are 0x10,0x11,0x12,0x13.
- Fairness after skip: only requesters 1 and 3 valid, `last_grant`=1 → requester 3 wins next, then 1.
- Start timeout: `uart_tx_busy` forced 0 and START_TIMEOUT=16 → `start_err` pulses 16 cycles after `uart_tx_en` with the correct id; no `frame_done`; `busy` drops; the next request is served normally.
- Reset mid-frame: assert `rst` for 1 cycle during WAIT_END → all outputs are 0 next cycle, no `frame_done`; a subsequent request from requester 1 while requester 0 is also valid grants requester 0 first.
- Late valid: `req_valid[1]` asserted during another frame and dropped before IDLE → no `req_ready[1]` and no frame for requester 1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_top transmitter among
// NUM_REQ requesters, with frame-end and start-timeout reporting.
module uart_tx_arbiter #(
    parameter int SIZE          = 8,
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 16,
    localparam int IDW = $clog2(NUM_REQ),
    localparam int CW  = $clog2(START_TIMEOUT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [SIZE-1:0]         uart_data_in,
    output logic                    uart_tx_en,
    input  logic                    uart_tx_busy,
    output logic [IDW-1:0]          grant_id,
    output logic                    frame_done,
    output logic [IDW-1:0]          frame_done_id,
    output logic                    start_err,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_START,
        WAIT_END
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(START_TIMEOUT - 1);

    state_t state, state_next;

    logic [CW-1:0]      cnt, cnt_d;
    logic [IDW-1:0]     last_grant, lg_d;
    logic [IDW-1:0]     win;
    logic               win_ok;
    logic [SIZE-1:0]    win_data;
    int                 idx;

    logic [NUM_REQ-1:0] ready_d;
    logic               tx_en_d;
    logic [SIZE-1:0]    data_d;
    logic [IDW-1:0]     gid_d;
    logic               done_d;
    logic               err_d;
    logic [IDW-1:0]     fid_d;
    logic               busy_d;

    // Scan from last_grant+1 upward; the first valid index wins.
    always_comb begin
        win    = '0;
        win_ok = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!win_ok && req_valid[IDW'(idx)]) begin
                win_ok = 1'b1;
                win    = IDW'(idx);
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == IDW'(i)) begin
                win_data = req_data[i*SIZE +: SIZE];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            last_grant    <= IDW'(NUM_REQ - 1);
            req_ready     <= '0;
            uart_tx_en    <= 1'b0;
            uart_data_in  <= '0;
            grant_id      <= '0;
            frame_done    <= 1'b0;
            frame_done_id <= '0;
            start_err     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_d;
            last_grant    <= lg_d;
            req_ready     <= ready_d;
            uart_tx_en    <= tx_en_d;
            uart_data_in  <= data_d;
            grant_id      <= gid_d;
            frame_done    <= done_d;
            frame_done_id <= fid_d;
            start_err     <= err_d;
            busy          <= busy_d;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (win_ok) state_next = LOAD;
            end
            LOAD: begin
                state_next = WAIT_START;
            end
            WAIT_START: begin
                if (uart_tx_busy) state_next = WAIT_END;
                else if (cnt == CNT_MAX) state_next = IDLE;
            end
            WAIT_END: begin
                if (!uart_tx_busy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Counter is 0 during LOAD and counts every edge after it, so the
    // timeout lands START_TIMEOUT cycles after the start pulse.
    always_comb begin
        ready_d = '0;
        tx_en_d = 1'b0;
        data_d  = uart_data_in;
        gid_d   = grant_id;
        lg_d    = last_grant;
        done_d  = 1'b0;
        err_d   = 1'b0;
        fid_d   = frame_done_id;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                if (win_ok) begin
                    ready_d[win] = 1'b1;
                    tx_en_d      = 1'b1;
                    data_d       = win_data;
                    gid_d        = win;
                    lg_d         = win;
                    cnt_d        = '0;
                end
            end
            LOAD: begin
                cnt_d = cnt + 1'b1;
            end
            WAIT_START: begin
                if (!uart_tx_busy) begin
                    if (cnt == CNT_MAX) begin
                        err_d = 1'b1;
                        fid_d = grant_id;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
            WAIT_END: begin
                if (!uart_tx_busy) begin
                    done_d = 1'b1;
                    fid_d  = grant_id;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
        busy_d = (state_next != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, corner sequences and randomized traffic
// against a cycle-stamped scoreboard of grants and frame outcomes.
module tb_uart_tx_arbiter;

    localparam int SIZE    = 8;
    localparam int NUM_REQ = 4;
    localparam int T       = 16;
    localparam int IDW     = $clog2(NUM_REQ);

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic [SIZE-1:0]         uart_data_in;
    logic                    uart_tx_en;
    logic                    uart_tx_busy;
    logic [IDW-1:0]          grant_id;
    logic                    frame_done;
    logic [IDW-1:0]          frame_done_id;
    logic                    start_err;
    logic                    busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .SIZE(SIZE),
        .NUM_REQ(NUM_REQ),
        .START_TIMEOUT(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .uart_data_in(uart_data_in),
        .uart_tx_en(uart_tx_en),
        .uart_tx_busy(uart_tx_busy),
        .grant_id(grant_id),
        .frame_done(frame_done),
        .frame_done_id(frame_done_id),
        .start_err(start_err),
        .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // scoreboard state
    int              cyc = 0;
    bit              in_flight = 1'b0;
    int              end_cyc = 0;
    bit              end_err = 1'b0;
    int              m_ptr = NUM_REQ - 1;
    logic [SIZE-1:0] m_data = '0;
    int              m_gid = 0;
    int              m_fid = 0;
    int              m_grants = 0;
    int              rdy_cnt[NUM_REQ];

    // next-frame transmitter behaviour, and what the responder uses
    bit nxt_tmo = 1'b0;
    int nxt_dly = 1;
    int nxt_len = 1;
    int cfg_dly = 0;
    int cfg_len = 1;

    // uart_top stand-in: busy rises cfg_dly cycles after tx_en, lasts cfg_len
    initial begin
        int dly;
        int len;
        uart_tx_busy = 1'b0;
        dly = 0;
        len = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                uart_tx_busy = 1'b0;
                dly = 0;
                len = 0;
            end else begin
                if (len > 0) begin
                    len--;
                    if (len == 0) uart_tx_busy = 1'b0;
                end else if (dly > 0) begin
                    dly--;
                    if (dly == 0) begin
                        uart_tx_busy = 1'b1;
                        len = cfg_len;
                    end
                end
                if (uart_tx_en && cfg_dly > 0) dly = cfg_dly;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int rr(input int p, input logic [NUM_REQ-1:0] v);
        int r;
        r = -1;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (v[(p + k) % NUM_REQ]) r = (p + k) % NUM_REQ;
        end
        return r;
    endfunction

    // one clock: predict from inputs sampled at the edge, then compare
    task automatic step();
        logic [NUM_REQ-1:0]      v;
        logic [NUM_REQ*SIZE-1:0] d;
        logic                    r;
        logic [NUM_REQ-1:0]      e_rdy;
        logic                    e_en;
        logic                    e_done;
        logic                    e_err;
        int                      w;
        v = req_valid;
        d = req_data;
        r = rst;
        @(posedge clk);
        #1;
        cyc++;
        e_rdy  = '0;
        e_en   = 1'b0;
        e_done = 1'b0;
        e_err  = 1'b0;
        if (r) begin
            in_flight = 1'b0;
            m_ptr     = NUM_REQ - 1;
            m_data    = '0;
            m_gid     = 0;
            m_fid     = 0;
        end else if (!in_flight && |v) begin
            w = rr(m_ptr, v);
            m_ptr = w;
            m_gid = w;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == w) m_data = d[i*SIZE +: SIZE];
            end
            e_rdy = NUM_REQ'(1) << w;
            e_en  = 1'b1;
            in_flight = 1'b1;
            m_grants++;
            if (nxt_tmo) begin
                cfg_dly = 0;
                end_err = 1'b1;
                end_cyc = cyc + T;
            end else begin
                cfg_dly = nxt_dly;
                cfg_len = nxt_len;
                end_err = 1'b0;
                end_cyc = cyc + nxt_dly + nxt_len + 1;
            end
        end else if (in_flight && cyc == end_cyc) begin
            e_done    = !end_err;
            e_err     = end_err;
            m_fid     = m_gid;
            in_flight = 1'b0;
        end
        chk("pulses", 64'({req_ready, uart_tx_en, frame_done, start_err}),
            64'({e_rdy, e_en, e_done, e_err}));
        chk("data_in", 64'(uart_data_in), 64'(m_data));
        chk("ids", 64'({grant_id, frame_done_id}),
            64'({IDW'(m_gid), IDW'(m_fid)}));
        chk("busy", 64'(busy), 64'(in_flight));
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) rdy_cnt[i]++;
        end
        req_valid = req_valid & ~req_ready;
    endtask

    task automatic run_frame(output int gid, output logic [SIZE-1:0] gdata,
                             output int lat, output int gap,
                             output bit saw_done, output bit saw_err);
        int  g0;
        int  t_en;
        bit  fin;
        g0 = m_grants;
        gid = -1;
        gdata = '0;
        lat = -1;
        gap = -1;
        saw_done = 1'b0;
        saw_err = 1'b0;
        t_en = 0;
        fin = 1'b0;
        for (int k = 1; k <= 200 && !fin; k++) begin
            step();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) gid = i;
            end
            if (uart_tx_en) begin
                gdata = uart_data_in;
                lat = k;
                t_en = cyc;
            end
            if (frame_done) begin
                saw_done = 1'b1;
                gap = cyc - t_en;
            end
            if (start_err) begin
                saw_err = 1'b1;
                gap = cyc - t_en;
            end
            if (m_grants > g0 && !in_flight) fin = 1'b1;
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL frame_bound cyc=%0d got=unfinished want=finished", cyc);
        end
    endtask

    typedef struct {
        logic [NUM_REQ-1:0] valid;
        logic [SIZE-1:0]    base;
        int                 dly;
        int                 len;
        bit                 tmo;
        int                 exp_id;
        logic [SIZE-1:0]    exp_data;
    } vec_t;

    localparam int NV = 14;
    vec_t tv[NV];

    initial begin
        int              gid;
        logic [SIZE-1:0] gdata;
        int              lat;
        int              gap;
        bit              sd;
        bit              se;
        int              c0;
        int              c1;

        // contention, fairness after skip, single request, timeouts, bounds
        tv[0]  = '{4'b1111, 8'h10, 3,  4, 1'b0, 0, 8'h10};
        tv[1]  = '{4'b1111, 8'h10, 1,  2, 1'b0, 1, 8'h11};
        tv[2]  = '{4'b1111, 8'h10, 5,  1, 1'b0, 2, 8'h12};
        tv[3]  = '{4'b1111, 8'h10, 2,  3, 1'b0, 3, 8'h13};
        tv[4]  = '{4'b1111, 8'h10, 4,  2, 1'b0, 0, 8'h10};
        tv[5]  = '{4'b1010, 8'h20, 2,  2, 1'b0, 1, 8'h21};
        tv[6]  = '{4'b1010, 8'h20, 3,  1, 1'b0, 3, 8'h23};
        tv[7]  = '{4'b1010, 8'h20, 1,  5, 1'b0, 1, 8'h21};
        tv[8]  = '{4'b0100, 8'hA3, 2,  9, 1'b0, 2, 8'hA5};
        tv[9]  = '{4'b0001, 8'h30, 1,  1, 1'b1, 0, 8'h30};
        tv[10] = '{4'b0010, 8'h40, 2,  2, 1'b0, 1, 8'h41};
        tv[11] = '{4'b1000, 8'h50, 15, 2, 1'b0, 3, 8'h53};
        tv[12] = '{4'b0100, 8'h60, 1,  1, 1'b0, 2, 8'h62};
        tv[13] = '{4'b1111, 8'h70, 1,  1, 1'b1, 3, 8'h73};

        for (int i = 0; i < NUM_REQ; i++) rdy_cnt[i] = 0;
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        step();
        step();
        rst = 1'b0;
        chk("reset_state",
            64'({req_ready, uart_tx_en, uart_data_in, grant_id, frame_done,
                 frame_done_id, start_err, busy}), 64'(0));

        for (int r = 0; r < NV; r++) begin
            nxt_tmo = tv[r].tmo;
            nxt_dly = tv[r].dly;
            nxt_len = tv[r].len;
            for (int i = 0; i < NUM_REQ; i++) begin
                req_data[i*SIZE +: SIZE] = tv[r].base + SIZE'(i);
            end
            req_valid = tv[r].valid;
            run_frame(gid, gdata, lat, gap, sd, se);
            req_valid = '0;
            chk($sformatf("vec%0d_id", r), 64'(gid), 64'(tv[r].exp_id));
            chk($sformatf("vec%0d_data", r), 64'(gdata), 64'(tv[r].exp_data));
            chk($sformatf("vec%0d_lat", r), 64'(lat), 64'(1));
            chk($sformatf("vec%0d_outcome", r), 64'({sd, se}),
                64'({!tv[r].tmo, tv[r].tmo}));
            chk($sformatf("vec%0d_gap", r), 64'(gap),
                64'(tv[r].tmo ? T : tv[r].dly + tv[r].len + 1));
        end

        // reset beats a grant on the same edge
        nxt_tmo = 1'b0;
        nxt_dly = 2;
        nxt_len = 3;
        req_valid = 4'b0100;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_prio_ready", 64'(req_ready), 64'(0));
        run_frame(gid, gdata, lat, gap, sd, se);
        chk("rst_prio_next_id", 64'(gid), 64'(2));

        // reset during WAIT_END drops the frame and restarts at requester 0
        nxt_dly = 1;
        nxt_len = 12;
        req_data[0 +: SIZE] = 8'h55;
        req_valid = 4'b0001;
        for (int k = 0; k < 5; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_zero",
            64'({req_ready, uart_tx_en, uart_data_in, grant_id, frame_done,
                 frame_done_id, start_err, busy}), 64'(0));
        nxt_len = 3;
        req_data[0 +: SIZE] = 8'h66;
        req_data[SIZE +: SIZE] = 8'h77;
        req_valid = 4'b0011;
        run_frame(gid, gdata, lat, gap, sd, se);
        chk("rst_rr_first", 64'(gid), 64'(0));
        run_frame(gid, gdata, lat, gap, sd, se);
        chk("rst_rr_second", 64'(gid), 64'(1));
        chk("rst_rr_second_data", 64'(gdata), 64'(8'h77));

        // valid raised and dropped while another frame is in flight
        nxt_dly = 2;
        nxt_len = 10;
        req_valid = 4'b0001;
        c0 = rdy_cnt[0];
        c1 = rdy_cnt[1];
        for (int k = 0; k < 30; k++) begin
            if (k == 4) req_valid[1] = 1'b1;
            if (k == 8) req_valid[1] = 1'b0;
            step();
        end
        chk("late_valid_r1", 64'(rdy_cnt[1] - c1), 64'(0));
        chk("late_valid_r0", 64'(rdy_cnt[0] - c0), 64'(1));

        // randomized traffic, transmitter behaviour and occasional reset
        for (int n = 0; n < 3000; n++) begin
            nxt_tmo = ($urandom_range(0, 5) == 0);
            nxt_dly = int'($urandom_range(1, T - 1));
            nxt_len = int'($urandom_range(1, 6));
            rst = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[i*SIZE +: SIZE] = SIZE'($urandom);
                end else if (req_valid[i] && $urandom_range(0, 63) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            step();
        end
        rst = 1'b0;
        req_valid = '0;
        for (int k = 0; k < 60; k++) step();
        chk("drain_idle", 64'(busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
